// File: rtl/reverb_fftb_stream_packer.sv
// Frames FFT bin samples (sop/eop checked against FRAME_LEN) and forwards them through a
// 2-entry skid buffer toward a stream-to-MM FIFO; 1-cycle latency, in_ready drops only while skid is full.
module reverb_fftb_stream_packer #(
    parameter int FRAME_LEN = 512,
    parameter int CNT_W     = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] in_real,
    input  logic [15:0] in_imag,
    input  logic        in_valid,
    input  logic        in_sop,
    input  logic        in_eop,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        err_clear,
    output logic        err_nosop,
    output logic        err_len,
    output logic [15:0] frame_count,
    output logic        busy
);

    typedef enum logic {IDLE, IN_FRAME} state_t;

    localparam logic [CNT_W-1:0] LAST_BIN = CNT_W'(FRAME_LEN - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] bin_cnt, bin_cnt_nxt;
    logic             accept, fwd, set_nosop, set_len, frame_done;

    logic             main_vld, skid_vld, skid_vld_nxt;
    logic [31:0]      main_dat, skid_dat, sample;

    assign accept = in_valid & in_ready;
    assign sample = {in_real, in_imag};

    always_comb begin
        state_nxt   = state;
        bin_cnt_nxt = bin_cnt;
        fwd         = 1'b0;
        set_nosop   = 1'b0;
        set_len     = 1'b0;
        frame_done  = 1'b0;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (in_sop) begin
                        fwd = 1'b1;
                        if (in_eop && (FRAME_LEN > 1)) begin
                            set_len = 1'b1;
                        end else begin
                            state_nxt   = IN_FRAME;
                            bin_cnt_nxt = CNT_W'(1);
                        end
                    end else begin
                        set_nosop = 1'b1;
                    end
                end
                IN_FRAME: begin
                    fwd = 1'b1;
                    if (in_sop) begin
                        // Restart: this sample becomes bin 0 of a new frame.
                        set_len     = 1'b1;
                        bin_cnt_nxt = CNT_W'(1);
                    end else if (bin_cnt == LAST_BIN) begin
                        frame_done  = 1'b1;
                        set_len     = ~in_eop;
                        state_nxt   = IDLE;
                        bin_cnt_nxt = '0;
                    end else if (in_eop) begin
                        set_len     = 1'b1;
                        state_nxt   = IDLE;
                        bin_cnt_nxt = '0;
                    end else begin
                        bin_cnt_nxt = bin_cnt + CNT_W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            bin_cnt     <= '0;
            err_nosop   <= 1'b0;
            err_len     <= 1'b0;
            frame_count <= '0;
        end else begin
            state   <= state_nxt;
            bin_cnt <= bin_cnt_nxt;
            // A new error wins over a simultaneous clear.
            if (set_nosop)      err_nosop <= 1'b1;
            else if (err_clear) err_nosop <= 1'b0;
            if (set_len)        err_len <= 1'b1;
            else if (err_clear) err_len <= 1'b0;
            if (frame_done)     frame_count <= frame_count + 16'd1;
        end
    end

    // Skid fills only when main is held and a new sample arrives.
    assign skid_vld_nxt = (main_vld & ~out_ready) ? (skid_vld | fwd) : 1'b0;

    always_ff @(posedge clock) begin
        if (reset) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_dat <= '0;
            skid_dat <= '0;
            in_ready <= 1'b0;
        end else begin
            skid_vld <= skid_vld_nxt;
            in_ready <= ~skid_vld_nxt;
            if (~main_vld | out_ready) begin
                if (skid_vld) begin
                    main_vld <= 1'b1;
                    main_dat <= skid_dat;
                end else begin
                    main_vld <= fwd;
                    if (fwd) main_dat <= sample;
                end
            end else if (fwd) begin
                skid_dat <= sample;
            end
        end
    end

    assign out_valid = main_vld;
    assign out_data  = main_dat;
    assign busy      = (state == IN_FRAME);

endmodule
